// File: rtl/zapper_shot_detector.sv
// rtl/zapper_shot_detector.sv - light-gun input conditioning and shot verification sequencer
module zapper_shot_detector #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LIGHT_MIN       = 4,
  parameter int TARGET_FRAMES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_in,
  input  logic       light_in,
  input  logic       frame_start,
  input  logic       enable,
  output logic       flash_black,
  output logic       flash_target,
  output logic       shot_fire,
  output logic       hit,
  output logic       miss,
  output logic       busy,
  output logic [7:0] shot_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LIGHT_MIN + 1);
  localparam logic [DW-1:0] DEB_LIMIT   = DW'(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] LIGHT_LIMIT = LW'(LIGHT_MIN);
  localparam logic [3:0]    FRAME_LIMIT = 4'(TARGET_FRAMES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    BLACK,
    TARGET,
    RESULT,
    REARM
  } state_t;

  state_t          state, state_n;
  logic            trig_s1, trig_s2, light_s1, light_s2;
  logic [DW-1:0]   deb_cnt;
  logic            trig_deb, trig_deb_q;
  logic            pull;
  logic            accept;
  logic [LW-1:0]   light_cnt, light_nxt;
  logic [3:0]      frame_cnt;
  logic            seen, dark_fail;

  // two-flop synchronizers; idle level is 1 for both active-low gun pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1  <= 1'b1;
      trig_s2  <= 1'b1;
      light_s1 <= 1'b1;
      light_s2 <= 1'b1;
    end else begin
      trig_s1  <= trigger_in;
      trig_s2  <= trig_s1;
      light_s1 <= light_in;
      light_s2 <= light_s1;
    end
  end

  // debounce: a new trigger level must persist DEBOUNCE_CYCLES cycles before it is adopted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt    <= '0;
      trig_deb   <= 1'b1;
      trig_deb_q <= 1'b1;
    end else begin
      trig_deb_q <= trig_deb;
      if (trig_s2 == trig_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LIMIT - DW'(1)) begin
        trig_deb <= trig_s2;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign pull = trig_deb_q & ~trig_deb;

  // saturating run length of consecutive synchronized light-detect cycles
  always_comb begin
    if (light_s2) begin
      light_nxt = '0;
    end else if (light_cnt == LIGHT_LIMIT) begin
      light_nxt = light_cnt;
    end else begin
      light_nxt = light_cnt + LW'(1);
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state and decoded outputs; a pull is only ever accepted from IDLE
  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    flash_black  = 1'b0;
    flash_target = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (pull && enable) begin
          accept  = 1'b1;
          state_n = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) state_n = BLACK;
      end
      BLACK: begin
        flash_black = 1'b1;
        if (frame_start) state_n = TARGET;
      end
      TARGET: begin
        flash_target = 1'b1;
        if (frame_start && frame_cnt >= FRAME_LIMIT) state_n = RESULT;
      end
      RESULT: begin
        hit     = seen & ~dark_fail;
        miss    = ~(seen & ~dark_fail);
        state_n = REARM;
      end
      REARM: begin
        if (trig_deb) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // shot bookkeeping: fire pulse, shot counter, light/frame counters and verdict flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_fire  <= 1'b0;
      shot_count <= 8'd0;
      light_cnt  <= '0;
      frame_cnt  <= 4'd0;
      seen       <= 1'b0;
      dark_fail  <= 1'b0;
    end else begin
      shot_fire <= accept;
      if (accept) shot_count <= shot_count + 8'd1;

      if (state == BLACK) begin
        light_cnt <= frame_start ? '0 : light_nxt;
        if (light_nxt == LIGHT_LIMIT) dark_fail <= 1'b1;
      end else if (state == TARGET) begin
        light_cnt <= light_nxt;
        if (light_nxt == LIGHT_LIMIT) seen <= 1'b1;
      end else begin
        light_cnt <= '0;
      end

      if (state == BLACK && frame_start) begin
        frame_cnt <= 4'd1;
      end else if (state == TARGET && frame_start && frame_cnt < FRAME_LIMIT) begin
        frame_cnt <= frame_cnt + 4'd1;
      end

      if (state == RESULT) begin
        seen      <= 1'b0;
        dark_fail <= 1'b0;
      end
    end
  end

endmodule

// File: doc/zapper_shot_detector.md
Name: zapper_shot_detector

Overview:
- Conditions the raw light-gun inputs (trigger_in, light_in) and runs the shot-verification sequence for duck_hunt.
- On a trigger pull it requests one all-black frame, then TARGET_FRAMES frames with the white target box, sampling the photodiode in each.
- Sits between the external gun pins and the duck_hunt game/render logic.
- Consumes frame_start from VGA timing; emits flash requests to the renderer and hit/miss pulses to game state.

Parameters:
- DEBOUNCE_CYCLES, 16, cycles the synchronized trigger must hold a new level before the debounced level changes (min 1).
- LIGHT_MIN, 4, consecutive synchronized light-detect cycles needed to count as "light seen" (min 1).
- TARGET_FRAMES, 1, number of target frames after the black frame (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- trigger_in  in  1  raw gun trigger, active-low (1 = released).
- light_in  in  1  raw photodiode, active-low (0 = light detected).
- frame_start  in  1  one-cycle pulse at the start of each VGA frame.
- enable  in  1  game accepts shots when 1.
- flash_black  out  1  renderer draws an all-black frame while 1.
- flash_target  out  1  renderer draws black screen plus white target box while 1.
- shot_fire  out  1  one-cycle pulse on an accepted shot.
- hit  out  1  one-cycle result pulse.
- miss  out  1  one-cycle result pulse.
- busy  out  1  1 in any state other than IDLE.
- shot_count  out  8  accepted shots since reset; wraps 255 -> 0.

Behaviour:
- Reset: all outputs 0, shot_count = 0, FSM = IDLE, debounced trigger = 1 (released), all counters 0, synchronizer flops = 1.
- Input synchronization: trigger_in and light_in each pass through a 2-flop synchronizer. All logic uses only the synchronized values.
- Debounce:
  - Counter increments each cycle the synchronized trigger differs from the debounced level.
  - Counter clears whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
- Pull event: debounced level transitions 1 -> 0.
- Latency: shot_fire is asserted exactly DEBOUNCE_CYCLES+3 clk edges after a clean trigger_in fall.
- FSM states: IDLE, WAIT_FRAME, BLACK, TARGET, RESULT, REARM.
- IDLE:
  - On a pull event with enable = 1: pulse shot_fire, increment shot_count, go to WAIT_FRAME.
  - A pull event with enable = 0 is discarded; no shot is latched for later.
- WAIT_FRAME:
  - Wait for the next frame_start, then go to BLACK with flash_black = 1.
  - A frame_start in the same cycle as pull acceptance does not count.
- BLACK:
  - Light counter tracks consecutive cycles with synchronized light = 0. It saturates at LIGHT_MIN and clears on any light = 1 cycle.
  - Reaching LIGHT_MIN sets the sticky dark_fail flag (anti-cheat, e.g. gun aimed at a lamp).
  - On the next frame_start: flash_black = 0, flash_target = 1, frame counter = 1, light counter clears, go to TARGET.
- TARGET:
  - Same light counter. Reaching LIGHT_MIN sets the sticky seen flag.
  - On each frame_start: if frame counter < TARGET_FRAMES, increment it and stay in TARGET; otherwise flash_target = 0 and go to RESULT.
- RESULT:
  - Single cycle. Pulse hit if seen = 1 and dark_fail = 0; otherwise pulse miss.
  - Exactly one of hit or miss pulses per accepted shot.
  - Clear both flags, go to REARM.
- REARM:
  - Stay until debounced trigger = 1, then go to IDLE.
  - Holding the trigger never auto-fires a second shot.
- enable deasserted mid-shot: the sequence still completes and reports its result.
- Pull events while busy = 1 are ignored.
- Asynchronous rst mid-shot: outputs drop to their reset values immediately, with no hit/miss pulse.
- flash_black and flash_target are never 1 in the same cycle.

Test Plan:
- Reset with trigger_in = 1, light_in = 1 -> all outputs 0, shot_count = 0, busy = 0.
- trigger_in falls, clean -> shot_fire at edge 19 after the fall (defaults), shot_count = 1, busy = 1; flash_black high for exactly one frame starting at the next frame_start.
- Shot with light_in = 0 for 10 cycles mid-TARGET -> hit pulse one cycle after the frame_start that ends TARGET; miss stays 0.
- Shot with light_in = 0 for only 3 cycles during TARGET -> miss (below LIGHT_MIN = 4).
- Shot with light_in held 0 throughout BLACK and TARGET -> miss.
- Trigger glitches of 5 cycles -> no shot_fire.
- Trigger held low after a result -> no second shot; release then pull again -> shot_count = 2.
- rst pulsed during TARGET -> flash_target = 0 and shot_count = 0 immediately, no hit/miss.
- 256 shots -> shot_count wraps to 0.
